// File: rtl/fp2int_stream_ctrl_if.sv
// Result stream from the fp2int sequencer to its consumer.
// Ready/valid handshake with an end-of-block marker.
interface fp2int_stream_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/fp2int_stream_ctrl.sv
// Block sequencer for the FP32-to-integer converter: buffer reads,
// converter feed, credit-protected result FIFO and output stream.
module fp2int_stream_ctrl #(
    parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16,
    parameter int CONV_LATENCY                = 5,
    parameter int ADDR_W                      = 12,
    parameter int FIFO_DEPTH                  = 8
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         start,
    input  logic [ADDR_W-1:0]                            base_addr,
    input  logic [ADDR_W:0]                              count,
    input  logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] bitwidth_in,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         mem_rd_en,
    output logic [ADDR_W-1:0]                            mem_rd_addr,
    input  logic [31:0]                                  mem_rd_data,
    output logic                                         conv_valid,
    output logic [$clog2(MAX_BITWIDTH_QUANTIZED_DATA):0] conv_bitwidth,
    output logic [31:0]                                  conv_value,
    input  logic                                         conv_result_rdy,
    input  logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0]       conv_result,
    fp2int_stream_ctrl_if.master                         os
);

    localparam int DW    = MAX_BITWIDTH_QUANTIZED_DATA;
    localparam int BW_W  = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam int CR_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CR_W-1:0]  DEPTH_C  = CR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [BW_W-1:0]   bw_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  popped;
    logic [CNT_W-1:0]  popped_nx;
    logic [CR_W-1:0]   credits;
    logic              conv_valid_q;

    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CR_W-1:0]   fifo_cnt;

    logic              start_acc;
    logic              issue;
    logic              hs;
    logic              fifo_nempty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credits count words between issue and output pop, so the
    // FIFO always has room for everything the converter emits.
    assign start_acc   = (state == IDLE) && start;
    assign issue       = (state == RUN) && (credits < DEPTH_C)
                         && (issued != count_q);
    assign fifo_nempty = (fifo_cnt != '0);
    assign hs          = fifo_nempty && os.out_ready;
    assign popped_nx   = popped + CNT_W'(hs);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && ((issued + 1'b1) == count_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (popped_nx == count_q) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            base_q       <= '0;
            count_q      <= '0;
            bw_q         <= '0;
            issued       <= '0;
            popped       <= '0;
            credits      <= '0;
            conv_valid_q <= 1'b0;
        end else begin
            state        <= state_nx;
            conv_valid_q <= issue;
            if (start_acc) begin
                base_q  <= base_addr;
                count_q <= count;
                bw_q    <= bitwidth_in;
                issued  <= '0;
                popped  <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + 1'b1;
                end
                popped <= popped_nx;
            end
            if (issue && !hs) begin
                credits <= credits + 1'b1;
            end else if (!issue && hs) begin
                credits <= credits - 1'b1;
            end
        end
    end

    // Storage is not reset; out_data is gated by valid instead.
    always_ff @(posedge clk) begin
        if (conv_result_rdy) begin
            fifo_mem[wr_ptr] <= conv_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (conv_result_rdy) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (hs) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (conv_result_rdy && !hs) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!conv_result_rdy && hs) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign mem_rd_en     = issue;
    assign mem_rd_addr   = issue ? (base_q + issued[ADDR_W-1:0]) : '0;
    assign conv_valid    = conv_valid_q;
    assign conv_value    = conv_valid_q ? mem_rd_data : '0;
    assign conv_bitwidth = bw_q;

    assign os.out_valid = fifo_nempty;
    assign os.out_data  = fifo_nempty ? fifo_mem[rd_ptr] : '0;
    assign os.out_last  = fifo_nempty && (popped == (count_q - 1'b1));

    // Expected converter strobes, used only to guard its contract.
    logic [CONV_LATENCY-1:0] fly;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fly <= '0;
        end else begin
            fly[0] <= conv_valid_q;
            for (int i = 1; i < CONV_LATENCY; i++) begin
                fly[i] <= fly[i-1];
            end
        end
    end

    a_credit_bound: assert property (
        @(posedge clk) disable iff (!rstn)
        credits <= DEPTH_C
    );

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rstn)
        !(conv_result_rdy && (fifo_cnt == DEPTH_C) && !hs)
    );

    a_conv_latency: assert property (
        @(posedge clk) disable iff (!rstn)
        conv_result_rdy |-> fly[CONV_LATENCY-1]
    );

endmodule

// File: tb/tb_fp2int_stream_ctrl.sv
// Directed bench for fp2int_stream_ctrl with a fixed-latency
// converter model and a registered word buffer.
module tb_fp2int_stream_ctrl;

    localparam int L  = 5;
    localparam int AW = 12;
    localparam int DW = 16;

    typedef struct {
        string       name;
        logic [11:0] base;
        logic [12:0] cnt;
        logic [4:0]  bw;
        int          hold;
        int          ign1;
        int          ign2;
        int          burst;
        int          resume;
        int          pre_res;
        int          first_ov;
        int          done_at;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [4:0]    bitwidth_in;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          conv_valid;
    logic [4:0]    conv_bitwidth;
    logic [31:0]   conv_value;
    logic          conv_result_rdy;
    logic [DW-1:0] conv_result;

    fp2int_stream_ctrl_if #(.DATA_W(DW)) os_if ();

    fp2int_stream_ctrl #(
        .MAX_BITWIDTH_QUANTIZED_DATA(DW),
        .CONV_LATENCY(L),
        .ADDR_W(AW),
        .FIFO_DEPTH(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .base_addr(base_addr),
        .count(count),
        .bitwidth_in(bitwidth_in),
        .busy(busy),
        .done(done),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .conv_valid(conv_valid),
        .conv_bitwidth(conv_bitwidth),
        .conv_value(conv_value),
        .conv_result_rdy(conv_result_rdy),
        .conv_result(conv_result),
        .os(os_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memword(input logic [11:0] a);
        return {8'hC3, a, a ^ 12'h5A5};
    endfunction

    // Stand-in conversion: fold the word and keep bw low bits.
    function automatic logic [15:0] conv_f(input logic [31:0] v,
                                           input logic [4:0]  bw);
        logic [31:0] mask;
        logic [15:0] x;
        mask = (32'h1 << bw) - 32'h1;
        x    = v[31:16] ^ v[15:0];
        return x & mask[15:0];
    endfunction

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= memword(mem_rd_addr);
    end

    logic        cv_v [L];
    logic [15:0] cv_d [L];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < L; i++) cv_v[i] <= 1'b0;
        end else begin
            cv_v[0] <= conv_valid;
            cv_d[0] <= conv_f(conv_value, conv_bitwidth);
            for (int i = 1; i < L; i++) begin
                cv_v[i] <= cv_v[i-1];
                cv_d[i] <= cv_d[i-1];
            end
        end
    end

    assign conv_result_rdy = cv_v[L-1];
    assign conv_result     = cv_d[L-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit         mon_en = 1'b0;
    int         t0_g;
    int         hold_g;
    logic [4:0] exp_bw;
    int         rd_c[$];
    logic [11:0] rd_a[$];
    int         hs_c[$];
    logic [15:0] hs_d[$];
    logic       hs_l[$];
    int         done_c[$];
    int         first_ov;
    int         bw_viol;
    int         cz_viol;
    int         n_res_pre;

    always @(negedge clk) begin
        int r;
        if (mon_en) begin
            r = cyc - t0_g;
            if (mem_rd_en) begin
                rd_c.push_back(r);
                rd_a.push_back(mem_rd_addr);
            end
            if (os_if.out_valid && os_if.out_ready) begin
                hs_c.push_back(r);
                hs_d.push_back(os_if.out_data);
                hs_l.push_back(os_if.out_last);
            end
            if (os_if.out_valid && first_ov < 0) first_ov = r;
            if (done) done_c.push_back(r);
            if (busy && conv_bitwidth != exp_bw) bw_viol++;
            if (!conv_valid && conv_value != 32'h0) cz_viol++;
            if (conv_result_rdy && r < hold_g) n_res_pre++;
        end
    end

    task automatic run(input vec_t v);
        int          t0;
        int          rel;
        int          ok;
        int          errs;
        logic [11:0] a;
        rd_c.delete();
        rd_a.delete();
        hs_c.delete();
        hs_d.delete();
        hs_l.delete();
        done_c.delete();
        first_ov  = -1;
        bw_viol   = 0;
        cz_viol   = 0;
        n_res_pre = 0;
        exp_bw    = v.bw;
        hold_g    = v.hold;
        base_addr   = v.base;
        count       = v.cnt;
        bitwidth_in = v.bw;
        start       = 1'b1;
        os_if.out_ready = (v.hold == 0);
        t0     = cyc;
        t0_g   = t0;
        mon_en = 1'b1;
        rel    = 0;
        while (done_c.size() == 0 && rel < 400) begin
            tick();
            rel = cyc - t0;
            os_if.out_ready = (rel >= v.hold);
            if (rel == v.ign1 || rel == v.ign2) begin
                start       = 1'b1;
                base_addr   = v.base ^ 12'hFFF;
                count       = 13'd2;
                bitwidth_in = 5'd3;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check({v.name, ".idle_after_done"}, busy, 0);
        mon_en = 1'b0;

        check({v.name, ".rd_count"}, rd_c.size(), v.cnt);
        ok = 0;
        for (int i = 0; i < v.burst && i < rd_c.size(); i++) begin
            if (rd_c[i] == i + 1) ok++;
        end
        check({v.name, ".rd_burst"}, ok, v.burst);
        if (v.burst < int'(v.cnt) && rd_c.size() > v.burst) begin
            check({v.name, ".rd_resume"}, rd_c[v.burst], v.resume);
        end
        errs = 0;
        for (int i = 0; i < rd_a.size(); i++) begin
            a = v.base + 12'(i);
            if (rd_a[i] != a) errs++;
        end
        check({v.name, ".rd_addr_errs"}, errs, 0);
        check({v.name, ".hs_count"}, hs_c.size(), v.cnt);
        check({v.name, ".first_out_valid"}, first_ov, v.first_ov);
        errs = 0;
        for (int i = 0; i < hs_d.size(); i++) begin
            a = v.base + 12'(i);
            if (hs_d[i] != conv_f(memword(a), v.bw)) errs++;
            if (hs_l[i] != (i == int'(v.cnt) - 1)) errs++;
        end
        check({v.name, ".data_last_errs"}, errs, 0);
        if (hs_c.size() > 0) begin
            check({v.name, ".hs_span"},
                  hs_c[hs_c.size()-1] - hs_c[0] + 1, v.cnt);
        end
        check({v.name, ".done_cycle"},
              (done_c.size() > 0) ? done_c[0] : -1, v.done_at);
        check({v.name, ".done_pulses"}, done_c.size(), 1);
        check({v.name, ".bitwidth_viol"}, bw_viol, 0);
        check({v.name, ".conv_value_zero_viol"}, cz_viol, 0);
        if (v.hold > 0) begin
            check({v.name, ".results_held"}, n_res_pre, v.pre_res);
        end
    endtask

    vec_t vecs[6];
    vec_t post;
    int   stale;

    initial begin
        vecs[0] = '{"basic", 12'h010, 13'd4,  5'd8,  0,  -1, -1, 4,  0,  0, 8,  12};
        vecs[1] = '{"full",  12'h100, 13'd64, 5'd16, 0,  -1, -1, 64, 0,  0, 8,  72};
        vecs[2] = '{"bp",    12'h200, 13'd20, 5'd12, 31, -1, -1, 8,  32, 8, 8,  51};
        vecs[3] = '{"zero",  12'h000, 13'd0,  5'd4,  0,  -1, -1, 0,  0,  0, -1, 1};
        vecs[4] = '{"wrap",  12'hFFE, 13'd4,  5'd16, 0,  -1, -1, 4,  0,  0, 8,  12};
        vecs[5] = '{"ign",   12'h300, 13'd6,  5'd8,  0,  3,  9,  6,  0,  0, 8,  14};
        post    = '{"post_rst", 12'h050, 13'd2, 5'd5, 0, -1, -1, 2,  0,  0, 8,  10};

        rstn        = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        count       = '0;
        bitwidth_in = '0;
        os_if.out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst.ctrl", {busy, done, mem_rd_en, conv_valid,
                           os_if.out_valid, os_if.out_last}, 0);
        check("rst.addr", mem_rd_addr, 0);
        check("rst.data", {conv_value, os_if.out_data, conv_bitwidth}, 0);
        tick();
        rstn = 1'b1;

        for (int i = 0; i < 6; i++) run(vecs[i]);

        base_addr   = 12'h040;
        count       = 13'd10;
        bitwidth_in = 5'd8;
        os_if.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_mid.ctrl", {busy, done, mem_rd_en, conv_valid,
                               os_if.out_valid, os_if.out_last}, 0);
        check("rst_mid.addr", mem_rd_addr, 0);
        check("rst_mid.data",
              {conv_value, os_if.out_data, conv_bitwidth}, 0);
        stale = 0;
        repeat (20) begin
            tick();
            @(negedge clk);
            if (os_if.out_valid || conv_result_rdy || mem_rd_en || busy)
                stale++;
        end
        check("rst_mid.stale_activity", stale, 0);
        run(post);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp2int_stream_ctrl.md
# fp2int_stream_ctrl

Sequencer for the FP32-to-integer quantisation datapath. After a `start` command, it:
- reads a block of FP32 words from a word-addressed buffer;
- issues them one per cycle into the fixed-latency, non-stallable converter pipeline;
- captures the converter results in a credit-protected FIFO;
- presents them on a ready/valid output stream with end-of-block marking.

It owns backpressure on behalf of the converter, which cannot stall.

## Interface
- MAX_BITWIDTH_QUANTIZED_DATA, 16, converter result width and maximum quantisation bitwidth
- CONV_LATENCY, 5, cycles from converter `values_rdy` to `result_rdy`
- ADDR_W, 12, buffer address width
- FIFO_DEPTH, 8, result FIFO entries and in-flight credit limit; must be ≥1; must be ≥ CONV_LATENCY+3 for full throughput
- clk  in  1  clock, rising edge
- rstn  in  1  reset, synchronous, active-low
- start  in  1  command strobe, accepted only in IDLE
- base_addr  in  ADDR_W  first word address, latched on start
- count  in  ADDR_W+1  number of words, latched on start
- bitwidth_in  in  $clog2(MAX_BITWIDTH_QUANTIZED_DATA)+1  target bitwidth, latched on start
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- mem_rd_en  out  1  buffer read strobe
- mem_rd_addr  out  ADDR_W  buffer read address
- mem_rd_data  in  32  FP32 word, valid the cycle after mem_rd_en
- conv_valid  out  1  drives converter `values_rdy`
- conv_bitwidth  out  $clog2(MAX_BITWIDTH_QUANTIZED_DATA)+1  latched bitwidth, constant while busy
- conv_value  out  32  drives converter `value`
- conv_result_rdy  in  1  converter result strobe
- conv_result  in  MAX_BITWIDTH_QUANTIZED_DATA  converter result
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  MAX_BITWIDTH_QUANTIZED_DATA  FIFO head
- out_last  out  1  high with the final element of the block

## Operation
**FSM states:** IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - start=1: latch base_addr, count, bitwidth_in; clear the issued and popped counters.
  - count=0: go to DONE; otherwise go to RUN.
- **RUN**
  - Issue a read when credits < FIFO_DEPTH: mem_rd_en=1, mem_rd_addr = base + issued.
  - Increment issued. The address wraps modulo 2^ADDR_W.
  - When issued reaches count, go to DRAIN.
- **DRAIN**
  - No further reads.
  - When popped == count, go to DONE.
- **DONE**
  - done=1 for exactly one cycle, then IDLE.
- start while busy is ignored; latched values do not change.

**Converter feed:**
- conv_valid is mem_rd_en delayed one register.
- conv_value = mem_rd_data (combinational pass-through). It is 0 when conv_valid=0.

**Credits:**
- Counter of width $clog2(FIFO_DEPTH+1).
- +1 on issue, −1 on output handshake (out_valid & out_ready). Both in one cycle: unchanged.
- Invariant: credits ≤ FIFO_DEPTH, so the FIFO never overflows.

**FIFO:**
- Written on conv_result_rdy; read on handshake.
- Simultaneous read and write when full or empty is legal.
- out_data holds the head; it is stable while out_valid=1 and out_ready=0.

**Output stream:**
- out_last = out_valid & (popped == count−1).

## Timing
**Reset values:** busy, done, mem_rd_en, conv_valid, out_valid, out_last = 0. mem_rd_addr, conv_value, out_data, conv_bitwidth = 0. State IDLE, FIFO empty, all counters 0.

**Reset mid-block:** everything returns to the reset values on the next edge. The converter shares rstn, so no stale results arrive afterwards.

**Latency (start sampled in cycle 0):**
- Cycle 1: first mem_rd_en.
- Cycle 2: conv_valid.
- Cycle 2+CONV_LATENCY: conv_result_rdy.
- Cycle 3+CONV_LATENCY: out_valid (cycle 8 at defaults).

**Throughput:** one word per cycle with out_ready held high and FIFO_DEPTH ≥ CONV_LATENCY+3.

**Backpressure:** out_ready=0 stops issue once credits reach FIFO_DEPTH. Results already in flight always fit in the FIFO.

**Completion:** final handshake in cycle k → DONE and done=1 in cycle k+1; IDLE in cycle k+2. A start in cycle k+2 is accepted.

## Test plan
- **Basic block:** base=0x010, count=4, bitwidth=8, out_ready=1.
  - mem_rd_en in cycles 1–4 with addresses 0x010–0x013.
  - out_valid in cycles 8–11; out_last in cycle 11; done in cycle 12.
- **Full throughput:** count=64, out_ready=1. Exactly 64 contiguous handshakes; no gap in mem_rd_en.
- **Backpressure:** count=20, out_ready=0 for cycles 0–30, then 1.
  - mem_rd_en deasserts after 8 issues.
  - FIFO holds 8 entries with no loss; all 20 results arrive in order.
- **Boundaries:**
  - count=0: done pulses in cycle 1; no mem_rd_en and no out_valid.
  - base=0xFFE, count=4: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Reset mid-block:** rstn=0 for one cycle while 5 words are in flight. All outputs are 0 on the next cycle and no stale out_valid appears; a following start of count=2 completes normally.
- **Ignored start:** start pulses while busy in RUN and in DRAIN. The latched count and bitwidth are unchanged and conv_bitwidth stays constant.
